// File: rtl/mode_select.sv
// Mode push-button conditioner: 2-flop sync, per-button debounce, press detect, one-hot mode request.
// Optional feature MODE_LOCK_EN: defers mode changes while busy, holding one pending request.
module mode_select #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_in,
  input  logic       busy,
  output logic [2:0] x_out,
  output logic       mode_chg,
  output logic [2:0] btn_level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       btn_level_d;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       rise;
  logic [2:0]       req;
  logic             req_valid;

  // Synchronize, then let each debounced level flip only after a full run of stable samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1       <= '0;
      sync2       <= '0;
      btn_level   <= '0;
      btn_level_d <= '0;
      for (int i = 0; i < 3; i++) cnt[i] <= '0;
    end else begin
      sync1       <= btn_in;
      sync2       <= sync1;
      btn_level_d <= btn_level;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          btn_level[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = btn_level & ~btn_level_d;

  // Simultaneous presses are ambiguous and produce no request.
  always_comb begin
    req       = rise;
    req_valid = 1'b0;
    case (rise)
      3'b001, 3'b010, 3'b100: req_valid = 1'b1;
      default:                req_valid = 1'b0;
    endcase
  end

`ifdef MODE_LOCK_EN
  logic [2:0] pending;

  // While busy, the latest differing request waits in pending and is applied once busy drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out    <= 3'b001;
      mode_chg <= 1'b0;
      pending  <= '0;
    end else if (busy) begin
      mode_chg <= 1'b0;
      if (req_valid) pending <= (req != x_out) ? req : 3'b000;
    end else if (req_valid) begin
      pending <= '0;
      if (req != x_out) begin
        x_out    <= req;
        mode_chg <= 1'b1;
      end else begin
        mode_chg <= 1'b0;
      end
    end else if (pending != 3'b000 && pending != x_out) begin
      x_out    <= pending;
      mode_chg <= 1'b1;
      pending  <= '0;
    end else begin
      mode_chg <= 1'b0;
      pending  <= '0;
    end
  end
`else
  logic unused_busy;
  assign unused_busy = busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_out    <= 3'b001;
      mode_chg <= 1'b0;
    end else if (req_valid && req != x_out) begin
      x_out    <= req;
      mode_chg <= 1'b1;
    end else begin
      mode_chg <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mode_select.sv
// Directed bench for mode_select with DEBOUNCE_CYCLES=4; expectations are hand-derived cycle counts.
module tb_mode_select;

  localparam int N = 4;
`ifdef MODE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_in;
  logic       busy;
  logic [2:0] x_out;
  logic       mode_chg;
  logic [2:0] btn_level;

  int checkCount = 0;
  int failCount  = 0;
  logic anyChg;

  mode_select #(.DEBOUNCE_CYCLES(N), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .busy(busy),
    .x_out(x_out), .mode_chg(mode_chg), .btn_level(btn_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (mode_chg) anyChg = 1'b1;
  endtask

  task automatic applyStimulus(input logic [2:0] b, input int cycles);
    btn_in = b;
    repeat (cycles) tick();
  endtask

  initial begin
    rst    = 1'b0;
    btn_in = 3'b000;
    busy   = 1'b0;
    anyChg = 1'b0;
    repeat (2) tick();
    checkOutput("reset_x", {5'b0, x_out}, 8'h01);
    checkOutput("reset_chg", {7'b0, mode_chg}, 8'h00);
    checkOutput("reset_level", {5'b0, btn_level}, 8'h00);
    rst = 1'b1;
    repeat (3) tick();

    // Test 1: single press of bit1
    applyStimulus(3'b010, 5);
    checkOutput("t1_level_e4", {5'b0, btn_level}, 8'h00);
    tick();
    checkOutput("t1_level_e5", {5'b0, btn_level}, 8'h02);
    checkOutput("t1_x_e5", {5'b0, x_out}, 8'h01);
    tick();
    checkOutput("t1_x_e6", {5'b0, x_out}, 8'h02);
    checkOutput("t1_chg_e6", {7'b0, mode_chg}, 8'h01);
    tick();
    checkOutput("t1_chg_e7", {7'b0, mode_chg}, 8'h00);
    applyStimulus(3'b000, 10);
    checkOutput("t1_release_level", {5'b0, btn_level}, 8'h00);
    checkOutput("t1_release_x", {5'b0, x_out}, 8'h02);

    // Test 2: bounce on bit2 then hold
    anyChg = 1'b0;
    applyStimulus(3'b100, 1);
    applyStimulus(3'b000, 1);
    applyStimulus(3'b100, 1);
    applyStimulus(3'b000, 1);
    applyStimulus(3'b100, 5);
    checkOutput("t2_level_pre", {5'b0, btn_level}, 8'h00);
    checkOutput("t2_nochg_pre", {7'b0, anyChg}, 8'h00);
    tick();
    checkOutput("t2_level_flip", {5'b0, btn_level}, 8'h04);
    checkOutput("t2_x_pre", {5'b0, x_out}, 8'h02);
    tick();
    checkOutput("t2_x", {5'b0, x_out}, 8'h04);
    checkOutput("t2_chg", {7'b0, mode_chg}, 8'h01);
    applyStimulus(3'b100, 6);
    checkOutput("t2_hold_x", {5'b0, x_out}, 8'h04);
    applyStimulus(3'b000, 10);

    // Test 3: simultaneous press is dropped
    anyChg = 1'b0;
    applyStimulus(3'b101, 6);
    checkOutput("t3_level", {5'b0, btn_level}, 8'h05);
    applyStimulus(3'b101, 4);
    checkOutput("t3_x", {5'b0, x_out}, 8'h04);
    checkOutput("t3_nochg", {7'b0, anyChg}, 8'h00);
    applyStimulus(3'b000, 10);

    // Test 4: return to free, then re-press free
    applyStimulus(3'b001, 7);
    checkOutput("t4_x_free", {5'b0, x_out}, 8'h01);
    checkOutput("t4_chg_free", {7'b0, mode_chg}, 8'h01);
    applyStimulus(3'b000, 10);
    anyChg = 1'b0;
    applyStimulus(3'b001, 6);
    checkOutput("t4_level_repress", {5'b0, btn_level}, 8'h01);
    applyStimulus(3'b001, 3);
    applyStimulus(3'b000, 10);
    checkOutput("t4_level_rel", {5'b0, btn_level}, 8'h00);
    checkOutput("t4_x_repress", {5'b0, x_out}, 8'h01);
    checkOutput("t4_nochg", {7'b0, anyChg}, 8'h00);

    // Test 5: reset mid-debounce
    applyStimulus(3'b100, 7);
    applyStimulus(3'b000, 10);
    checkOutput("t5_x_pre", {5'b0, x_out}, 8'h04);
    applyStimulus(3'b010, 4);
    rst = 1'b0;
    #1;
    checkOutput("t5_x_async", {5'b0, x_out}, 8'h01);
    checkOutput("t5_chg_async", {7'b0, mode_chg}, 8'h00);
    checkOutput("t5_level_async", {5'b0, btn_level}, 8'h00);
    anyChg = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    applyStimulus(3'b010, 5);
    checkOutput("t5_level_e4", {5'b0, btn_level}, 8'h00);
    tick();
    checkOutput("t5_level_e5", {5'b0, btn_level}, 8'h02);
    checkOutput("t5_nochg_pre", {7'b0, anyChg}, 8'h00);
    tick();
    checkOutput("t5_x_e6", {5'b0, x_out}, 8'h02);
    checkOutput("t5_chg_e6", {7'b0, mode_chg}, 8'h01);
    applyStimulus(3'b000, 10);

    // Test 6: busy gating (immediate apply when the lock is not built)
    applyStimulus(3'b001, 7);
    applyStimulus(3'b000, 10);
    checkOutput("t6_x_start", {5'b0, x_out}, 8'h01);
    busy = 1'b1;
    applyStimulus(3'b010, 7);
    checkOutput("t6_x_busy1", {5'b0, x_out}, LOCK ? 8'h01 : 8'h02);
    applyStimulus(3'b000, 10);
    applyStimulus(3'b100, 7);
    applyStimulus(3'b000, 10);
    checkOutput("t6_x_busy2", {5'b0, x_out}, LOCK ? 8'h01 : 8'h04);
    anyChg = 1'b0;
    busy = 1'b0;
    tick();
    checkOutput("t6_x_release", {5'b0, x_out}, 8'h04);
    checkOutput("t6_chg_release", {7'b0, mode_chg}, LOCK ? 8'h01 : 8'h00);
    tick();
    checkOutput("t6_chg_after", {7'b0, mode_chg}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
